// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM-stage controls and a word-wide data memory port.
// Issues aligned requests, builds store lanes, captures read data and stalls the pipeline.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemSize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mem_read_data,
  output logic [1:0]        offset,
  output logic              MemReadSize,
  output logic              load_done,
  output logic              stall,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              size_q;
  logic [15:0]       sdata_q;
  logic              load_q;
  logic [31:0]       rdata_q;
  logic [1:0]        off_q;
  logic              rsize_q;
  logic              misalign_q;
  logic              bus_err_q;

  logic req_valid;
  logic misaligned;
  logic accept;
  logic capture;
  logic timeout;

  assign req_valid  = MemRead | MemWrite;
  assign misaligned = MemSize & addr[0];
  assign accept     = (state_q == StIdle) & req_valid & ~misaligned;

  // State register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; counter clears on entry to each waiting state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        if (mem_ready) begin
          if (!load_q) begin
            state_d = StDone;
          end else if (mem_rvalid) begin
            capture = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWaitR;
            cnt_d   = '0;
          end
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitR: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request, capture and error-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= 1'b0;
      sdata_q    <= '0;
      load_q     <= 1'b0;
      rdata_q    <= '0;
      off_q      <= '0;
      rsize_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        size_q  <= MemSize;
        sdata_q <= store_data;
        load_q  <= MemRead;
      end
      if (capture) begin
        rdata_q <= mem_rdata;
        off_q   <= addr_q[1:0];
        rsize_q <= size_q;
      end
      misalign_q <= (state_q == StIdle) & req_valid & misaligned;
      bus_err_q  <= timeout;
    end
  end

  // Outputs
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    load_done = 1'b0;
    stall     = accept;
    unique case (state_q)
      StIdle: ;
      StReq: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = ~load_q;
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (!load_q) begin
          if (size_q) begin
            mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{sdata_q}};
          end else begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{sdata_q[7:0]}};
          end
        end
      end
      StWaitR: stall = 1'b1;
      // A timed-out load reaches DONE with bus_err set and must not report data
      StDone:  load_done = load_q & ~bus_err_q;
      default: ;
    endcase
  end

  assign mem_read_data = rdata_q;
  assign offset        = off_q;
  assign MemReadSize   = rsize_q;
  assign misalign_err  = misalign_q;
  assign bus_err       = bus_err_q;

endmodule
